// File: rtl/twi_slave_logic_if.sv
// Bus/handshake bundle for twi_slave_logic: the TWI lines plus the
// register-file strobe port. The slave modport is the responder's view,
// the master modport is the view of whatever drives the bus and serves the
// register file.
interface twi_slave_logic_if;
  logic       iScl;
  logic       iSda;
  logic       oSda;
  logic [7:0] oRegAddr;
  logic [7:0] oRegWrData;
  logic       oRegWrEn;
  logic       oRegRdEn;
  logic [7:0] iRegRdData;
  logic       oBusy;

  modport slave (
    input  iScl, iSda, iRegRdData,
    output oSda, oRegAddr, oRegWrData, oRegWrEn, oRegRdEn, oBusy
  );

  modport master (
    output iScl, iSda, iRegRdData,
    input  oSda, oRegAddr, oRegWrData, oRegWrEn, oRegRdEn, oBusy
  );
endinterface

// File: rtl/twi_slave_logic.sv
// TWI (I2C) target: START/STOP decode, 7-bit address match, 8-bit register
// pointer, byte moves to/from a register file over one-cycle strobes.
// Optional macro TWI_SLAVE_GLITCH_FILTER_EN inserts a stable-count filter of
// FILTER_LEN cycles after the synchronisers (edge latency 3 + FILTER_LEN).
//
// state     | meaning
// S_IDLE    | bus free, waiting for START
// S_ADDR    | shifting the address/R-W byte
// S_A_ACK   | ACKing the address byte
// S_PTR     | shifting the register pointer byte
// S_P_ACK   | ACKing the pointer byte
// S_WR      | shifting a write data byte
// S_W_ACK   | ACKing a write data byte, pointer bumped at its end
// S_RD      | driving a read data byte MSB first
// S_RD_MACK | released, sampling the master ACK/NACK
// S_IGNORE  | not addressed or NACKed, waiting for START/STOP
module twi_slave_logic #(
  parameter logic [6:0] SLAVE_ADDR = 7'h21,
  parameter int         FILTER_LEN = 4
) (
  input logic             iPlbClk,
  input logic             iPlbReset,
  twi_slave_logic_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_A_ACK, S_PTR, S_P_ACK, S_WR, S_W_ACK, S_RD, S_RD_MACK, S_IGNORE
  } state_t;

  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("FILTER_LEN must be at least 1");
  end

  logic scl_s1, scl_s2, sda_s1, sda_s2;
  logic scl_f, sda_f, scl_q, sda_q;

  // Two-flop synchronisers on the asynchronous bus lines.
  always_ff @(posedge iPlbClk) begin
    if (iPlbReset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= bus.iScl;
      scl_s2 <= scl_s1;
      sda_s1 <= bus.iSda;
      sda_s2 <= sda_s1;
    end
  end

`ifdef TWI_SLAVE_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  logic [FCW-1:0] scl_cnt, sda_cnt;

  // Stable-count filter: a line only changes after FILTER_LEN differing samples in a row.
  always_ff @(posedge iPlbClk) begin
    if (iPlbReset) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_s2 == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FCW'(FILTER_LEN - 1)) begin
        scl_f   <= scl_s2;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_s2 == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FCW'(FILTER_LEN - 1)) begin
        sda_f   <= sda_s2;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end
`else
  assign scl_f = scl_s2;
  assign sda_f = sda_s2;
`endif

  // Previous-sample copies for edge detection.
  always_ff @(posedge iPlbClk) begin
    if (iPlbReset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

  state_t     state, state_n;
  logic       ack_ph, ack_ph_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n, byte_in;
  logic       rw, rw_n;
  logic       osda, osda_n;
  logic [7:0] reg_addr, addr_n, wr_data, wdata_n;
  logic       wr_en, wr_en_n, rd_en, rd_en_n, rd_pend, busy, busy_n;

  assign byte_in = {shreg[6:0], sda_f};

  // State and datapath registers; reset releases SDA on the edge it is sampled.
  always_ff @(posedge iPlbClk) begin
    if (iPlbReset) begin
      state    <= S_IDLE;
      ack_ph   <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rw       <= 1'b0;
      osda     <= 1'b1;
      reg_addr <= '0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      rd_pend  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      ack_ph   <= ack_ph_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      rw       <= rw_n;
      osda     <= osda_n;
      reg_addr <= addr_n;
      wr_data  <= wdata_n;
      wr_en    <= wr_en_n;
      rd_en    <= rd_en_n;
      rd_pend  <= rd_en;
      busy     <= busy_n;
    end
  end

  // Next-state and datapath decode; bus conditions win over bit handling.
  always_comb begin
    state_n   = state;
    ack_ph_n  = ack_ph;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    rw_n      = rw;
    osda_n    = osda;
    addr_n    = reg_addr;
    wdata_n   = wr_data;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    busy_n    = busy;
    if (start_det) begin
      state_n   = S_ADDR;
      bit_cnt_n = '0;
      ack_ph_n  = 1'b0;
      osda_n    = 1'b1;
      busy_n    = 1'b0;
    end else if (stop_det) begin
      state_n  = S_IDLE;
      ack_ph_n = 1'b0;
      osda_n   = 1'b1;
      busy_n   = 1'b0;
    end else begin
      case (state)
        S_ADDR, S_PTR, S_WR: begin
          if (scl_rise) begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              ack_ph_n = 1'b0;
              if (state == S_ADDR) begin
                if (shreg[6:0] == SLAVE_ADDR) begin
                  rw_n    = sda_f;
                  busy_n  = 1'b1;
                  state_n = S_A_ACK;
                end else begin
                  state_n = S_IGNORE;
                end
              end else if (state == S_PTR) begin
                addr_n  = byte_in;
                state_n = S_P_ACK;
              end else begin
                wdata_n = byte_in;
                wr_en_n = 1'b1;
                state_n = S_W_ACK;
              end
            end
          end
        end
        S_A_ACK, S_P_ACK, S_W_ACK: begin
          if (scl_fall) begin
            if (!ack_ph) begin
              osda_n   = 1'b0;
              ack_ph_n = 1'b1;
              // Fetch the first read byte early so its MSB is ready at the ACK release.
              if (state == S_A_ACK && rw) rd_en_n = 1'b1;
            end else begin
              osda_n    = 1'b1;
              ack_ph_n  = 1'b0;
              bit_cnt_n = '0;
              if (state == S_A_ACK) begin
                if (rw) begin
                  state_n = S_RD;
                  osda_n  = shreg[7];
                  shreg_n = {shreg[6:0], 1'b1};
                end else begin
                  state_n = S_PTR;
                end
              end else begin
                state_n = S_WR;
                if (state == S_W_ACK) addr_n = reg_addr + 8'd1;
              end
            end
          end
        end
        S_RD: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              osda_n   = 1'b1;
              ack_ph_n = 1'b0;
              state_n  = S_RD_MACK;
            end else begin
              osda_n  = shreg[7];
              shreg_n = {shreg[6:0], 1'b1};
            end
          end
        end
        S_RD_MACK: begin
          if (scl_rise && !ack_ph) begin
            if (!sda_f) begin
              ack_ph_n = 1'b1;
              addr_n   = reg_addr + 8'd1;
              rd_en_n  = 1'b1;
            end else begin
              state_n = S_IGNORE;
            end
          end else if (scl_fall && ack_ph) begin
            ack_ph_n  = 1'b0;
            bit_cnt_n = '0;
            state_n   = S_RD;
            osda_n    = shreg[7];
            shreg_n   = {shreg[6:0], 1'b1};
          end
        end
        default: ;
      endcase
    end
    // Read data arrives one cycle after the strobe; no bit moves in that cycle.
    if (rd_pend) shreg_n = bus.iRegRdData;
  end

  assign bus.oSda       = osda;
  assign bus.oRegAddr   = reg_addr;
  assign bus.oRegWrData = wr_data;
  assign bus.oRegWrEn   = wr_en;
  assign bus.oRegRdEn   = rd_en;
  assign bus.oBusy      = busy;

endmodule

// File: tb/tb_twi_slave_logic.sv
// Directed bench for twi_slave_logic: bit-banged TWI master, wired-AND SDA,
// registered register-file model returning ~address.
module tb_twi_slave_logic;
  localparam int Q = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic [7:0] rd_data = 8'h00;

  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int low_cnt = 0;
  logic [7:0] wr_addr_log [8];
  logic [7:0] wr_data_log [8];
  logic [7:0] rd_addr_log [8];

  twi_slave_logic_if bus ();
  assign bus.iScl       = m_scl;
  assign bus.iSda       = m_sda & bus.oSda;
  assign bus.iRegRdData = rd_data;

  twi_slave_logic #(.SLAVE_ADDR(7'h21), .FILTER_LEN(4)) dut (
    .iPlbClk  (clk),
    .iPlbReset(rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Register-file model and strobe/SDA monitors.
  always @(posedge clk) begin
    if (bus.oRegRdEn) begin
      rd_data <= ~bus.oRegAddr;
      rd_addr_log[rd_cnt % 8] <= bus.oRegAddr;
      rd_cnt <= rd_cnt + 1;
    end
    if (bus.oRegWrEn) begin
      wr_addr_log[wr_cnt % 8] <= bus.oRegAddr;
      wr_data_log[wr_cnt % 8] <= bus.oRegWrData;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.oSda === 1'b0) low_cnt <= low_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, input bit glitch, output logic line);
    wait_n(Q);
    m_sda = b;
    wait_n(Q);
    m_scl = 1'b1;
    if (glitch) begin
      wait_n(3);
      m_scl = 1'b0;
      wait_n(2);
      m_scl = 1'b1;
      wait_n(1);
    end else begin
      wait_n(Q);
    end
    line = bus.iSda;
    wait_n(Q);
    m_scl = 1'b0;
  endtask

  task automatic do_start();
    m_sda = 1'b0;
    wait_n(2 * Q);
    m_scl = 1'b0;
  endtask

  task automatic do_rstart();
    wait_n(Q);
    m_sda = 1'b1;
    wait_n(Q);
    m_scl = 1'b1;
    wait_n(Q);
    m_sda = 1'b0;
    wait_n(Q);
    m_scl = 1'b0;
  endtask

  task automatic do_stop();
    wait_n(Q);
    m_sda = 1'b0;
    wait_n(Q);
    m_scl = 1'b1;
    wait_n(Q);
    m_sda = 1'b1;
    wait_n(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch7, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) bit_x(b[i], glitch7 && (i == 7), l);
    bit_x(1'b1, 1'b0, l);
    ack = (l === 1'b0);
  endtask

  task automatic recv_byte(input bit ack_in, output logic [7:0] d);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, 1'b0, l);
      d[i] = l;
    end
    bit_x(ack_in ? 1'b0 : 1'b1, 1'b0, l);
  endtask

  initial begin
    logic a0, a1, a2, a3;
    logic [7:0] d0, d1, d2;
    int wr0, rd0, low0;

    // Reset with the bus idle
    wait_n(2);
    check("rst_osda", bus.oSda, 1'b1);
    check("rst_addr", bus.oRegAddr, 8'h00);
    check("rst_wdata", bus.oRegWrData, 8'h00);
    check("rst_wren", bus.oRegWrEn, 1'b0);
    check("rst_rden", bus.oRegRdEn, 1'b0);
    check("rst_busy", bus.oBusy, 1'b0);
    rst = 1'b0;
    wait_n(4);

    // Write: pointer 0x10, data A5, 5A
    wr0 = wr_cnt;
    do_start();
    send_byte(8'h42, 1'b0, a0);
    check("wr_busy", bus.oBusy, 1'b1);
    send_byte(8'h10, 1'b0, a1);
    send_byte(8'hA5, 1'b0, a2);
    send_byte(8'h5A, 1'b0, a3);
    do_stop();
    check("wr_ack_addr", a0, 1'b1);
    check("wr_ack_ptr", a1, 1'b1);
    check("wr_ack_d0", a2, 1'b1);
    check("wr_ack_d1", a3, 1'b1);
    check("wr_count", wr_cnt - wr0, 2);
    check("wr0_addr", wr_addr_log[wr0 % 8], 8'h10);
    check("wr0_data", wr_data_log[wr0 % 8], 8'hA5);
    check("wr1_addr", wr_addr_log[(wr0 + 1) % 8], 8'h11);
    check("wr1_data", wr_data_log[(wr0 + 1) % 8], 8'h5A);
    check("wr_final_addr", bus.oRegAddr, 8'h12);
    check("wr_busy_after_stop", bus.oBusy, 1'b0);

    // Read with pointer wrap: FE, FF, 00 -> data 01, 00, FF
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    do_start();
    send_byte(8'h42, 1'b0, a0);
    send_byte(8'hFE, 1'b0, a1);
    do_rstart();
    send_byte(8'h43, 1'b0, a2);
    recv_byte(1'b1, d0);
    recv_byte(1'b1, d1);
    recv_byte(1'b0, d2);
    check("rd_osda_after_nack", bus.oSda, 1'b1);
    do_stop();
    check("rd_ack_addr_r", a2, 1'b1);
    check("rd_d0", d0, 8'h01);
    check("rd_d1", d1, 8'h00);
    check("rd_d2", d2, 8'hFF);
    check("rd_count", rd_cnt - rd0, 3);
    check("rd0_addr", rd_addr_log[rd0 % 8], 8'hFE);
    check("rd1_addr", rd_addr_log[(rd0 + 1) % 8], 8'hFF);
    check("rd2_addr", rd_addr_log[(rd0 + 2) % 8], 8'h00);
    check("rd_final_addr", bus.oRegAddr, 8'h00);
    check("rd_no_write", wr_cnt - wr0, 0);

    // Address miss
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    low0 = low_cnt;
    do_start();
    send_byte(8'h44, 1'b0, a0);
    check("miss_busy", bus.oBusy, 1'b0);
    send_byte(8'h00, 1'b0, a1);
    do_stop();
    check("miss_ack_addr", a0, 1'b0);
    check("miss_ack_data", a1, 1'b0);
    check("miss_sda_low_cycles", low_cnt - low0, 0);
    check("miss_strobes", (wr_cnt - wr0) + (rd_cnt - rd0), 0);

    // Reset in the middle of a read while a 0 bit is driven (pointer 80 -> data 7F)
    do_start();
    send_byte(8'h42, 1'b0, a0);
    send_byte(8'h80, 1'b0, a1);
    do_rstart();
    send_byte(8'h43, 1'b0, a2);
    wait_n(10);
    check("mid_rd_bit7_low", bus.oSda, 1'b0);
    rst = 1'b1;
    wait_n(1);
    check("mid_rst_osda", bus.oSda, 1'b1);
    check("mid_rst_busy", bus.oBusy, 1'b0);
    check("mid_rst_addr", bus.oRegAddr, 8'h00);
    rst = 1'b0;
    m_scl = 1'b1;
    wait_n(Q);
    m_sda = 1'b1;
    wait_n(2 * Q);
    do_start();
    send_byte(8'h42, 1'b0, a0);
    check("post_rst_ack", a0, 1'b1);
    do_stop();

    // SCL glitch during bit 7 of a data byte (A5 to pointer 30)
    wr0 = wr_cnt;
    do_start();
    send_byte(8'h42, 1'b0, a0);
    send_byte(8'h30, 1'b0, a1);
    send_byte(8'hA5, 1'b1, a2);
    do_stop();
    check("glitch_wr_count", wr_cnt - wr0, 1);
    check("glitch_wr_addr", wr_addr_log[wr0 % 8], 8'h30);
`ifdef TWI_SLAVE_GLITCH_FILTER_EN
    check("glitch_wr_data", wr_data_log[wr0 % 8], 8'hA5);
`else
    // Unfiltered, the glitch is an extra SCL pulse: bit 7 is taken twice -> 1101_0010.
    check("glitch_wr_data", wr_data_log[wr0 % 8], 8'hD2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/twi_slave_logic.md
Name: twi_slave_logic

Overview:
- TWI (I2C) responder: the target end of the bus driven by the team's TWI master pcore.
- Decodes START/STOP, matches a 7-bit address, holds an 8-bit register pointer and moves bytes to and from a user register file over a simple read/write strobe port.
- Used as the on-chip target for config traffic and as the loop-back partner when verifying the master.

Parameters:
- SLAVE_ADDR, 7'h21, 7-bit bus address this block answers to.
- FILTER_LEN, 4, clock cycles SCL/SDA must be stable before a change is accepted (used only with the optional feature).

Ports:
- iPlbClk  in  1  system clock; must be at least 8x the SCL rate.
- iPlbReset  in  1  reset; synchronous, active-high.
- iScl  in  1  bus clock, asynchronous.
- iSda  in  1  bus data, asynchronous.
- oSda  out  1  open-drain data drive: 0 = pull low, 1 = release.
- oRegAddr  out  8  register pointer.
- oRegWrData  out  8  write byte.
- oRegWrEn  out  1  one-cycle write strobe; oRegAddr and oRegWrData are valid during it.
- oRegRdEn  out  1  one-cycle read request at oRegAddr.
- iRegRdData  in  8  read data, sampled exactly 1 cycle after oRegRdEn.
- oBusy  out  1  high from an address match until the next STOP or START.

Behaviour:
- Reset (sync, iPlbReset=1 at a rising edge): state IDLE, oSda=1, oRegAddr=0, oRegWrData=0, oRegWrEn=0, oRegRdEn=0, oBusy=0, all synchroniser flops loaded with 1.
- Synchronisation: iScl and iSda each go through a 2-flop synchroniser. Edges are detected on the synchronised copies, so edge-to-action latency is 3 cycles.
- START: SDA falls while SCL is high. From any state, clear the bit counter and go to ADDR. This also covers repeated START.
- STOP: SDA rises while SCL is high. From any state, go to IDLE, release oSda, drop oBusy.
- Bit timing: bits are sampled on synced SCL rising edges. oSda changes only on the cycle after a synced SCL falling edge. A START/STOP is never treated as a data bit.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first.
    - bits[7:1]==SLAVE_ADDR: go to ACK, set oBusy.
    - No match: go to IGNORE and never drive oSda.
  - ACK: after the 8th SCL falling edge, oSda=0 for one SCL period, released on the following falling edge.
  - After the address ACK:
    - R/W=0: go to PTR.
    - R/W=1: pulse oRegRdEn, latch iRegRdData one cycle later into the shift register, go to RD.
  - PTR: shift 8 bits into oRegAddr, ACK, go to WR.
  - WR: shift 8 bits.
    - On the 8th rising edge: load oRegWrData, pulse oRegWrEn for 1 cycle with the current oRegAddr.
    - Then ACK, increment oRegAddr, remain in WR.
  - RD:
    - Drive the shift register MSB first (bit driven after the SCL falling edge).
    - After 8 bits, release oSda and sample the master ACK on the 9th rising edge.
    - ACK=0: increment oRegAddr, pulse oRegRdEn, reload, stay in RD.
    - ACK=1 (NACK): go to IGNORE.
  - IGNORE: oSda=1; wait for START or STOP.
- oRegAddr increment wraps 8'hFF to 8'h00.
- A write with only the pointer byte (STOP after PTR ACK) updates oRegAddr with no oRegWrEn. The next read transfer starts at that pointer.
- Simultaneous events:
  - START/STOP detection has priority over bit sampling in the same cycle.
  - Reset has priority over everything. Reset mid-transfer releases oSda in the same cycle the reset is sampled.
- The block never stretches SCL.

Optional Feature:
- Macro: TWI_SLAVE_GLITCH_FILTER_EN.
- Defined: after the synchroniser, each line passes through a stable-count filter. The filtered value changes only after FILTER_LEN consecutive equal samples. Pulses shorter than FILTER_LEN cycles are ignored. Edge latency becomes 3+FILTER_LEN cycles.
- Undefined: no filter; latency is 3 cycles; FILTER_LEN is unused.

Test Plan:
- Reset: hold iPlbReset 2 cycles, bus idle (1/1) -> oSda=1, oRegAddr=00, strobes 0, oBusy=0.
- Write: START, 0x42, 0x10, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; oRegWrEn pulses with (10,A5) then (11,5A); final oRegAddr=12.
- Read: START, 0x42, 0xFE, Sr, 0x43, read 3 bytes (ACK, ACK, NACK), STOP; iRegRdData = ~oRegAddr -> SDA bytes 01, 00, FF; pointer wraps FE->FF->00; oSda released after the NACK.
- Address miss: START, 0x44, 0x00, STOP -> oSda stays 1 throughout, no strobes, oBusy=0.
- Reset mid-read: assert iPlbReset while driving a 0 data bit -> oSda=1 the same cycle it is sampled; state IDLE; the next START with 0x42 is ACKed.
- Filter (macro defined, FILTER_LEN=4): 2-cycle low glitch on SCL during a data byte -> byte received unchanged, no extra bit; with the macro undefined, the same glitch corrupts the byte (documents the difference).
